// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer.
//   state_t      : sequencer control states (IDLE, RUN, PAUSED)
//   MODE_*       : per-phase output mode codes
//   mode_out()   : decodes one mode code against operands a and b
package phase_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_ONE  = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_AND  = 2'b11;

  function automatic logic mode_out(input logic [1:0] mode, input logic a, input logic b);
    logic r;
    case (mode)
      MODE_ZERO: r = 1'b0;
      MODE_ONE:  r = 1'b1;
      MODE_XOR:  r = a ^ b;
      MODE_AND:  r = a & b;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle of the phase sequencer.
//   master : drives start, pause, abort, loop_en, dwell, mode, a, b;
//            observes out, phase, busy, step, done
//   slave  : the sequencer side (directions mirrored)
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8,
  parameter int PH_W       = $clog2(NUM_PHASES)
);
  logic                        start;
  logic                        pause;
  logic                        abort;
  logic                        loop_en;
  logic [NUM_PHASES*CNT_W-1:0] dwell;
  logic [2*NUM_PHASES-1:0]     mode;
  logic                        a;
  logic                        b;
  logic                        out;
  logic [PH_W-1:0]             phase;
  logic                        busy;
  logic                        step;
  logic                        done;

  modport master (
    output start, pause, abort, loop_en, dwell, mode, a, b,
    input  out, phase, busy, step, done
  );

  modport slave (
    input  start, pause, abort, loop_en, dwell, mode, a, b,
    output out, phase, busy, step, done
  );
endinterface

// File: rtl/phase_sequencer_out_mux.sv
// Output mode decoder for the phase sequencer.
//   mode   : 2-bit mode code of the current phase
//   a, b   : logic operands
//   enable : high while the sequencer is active; forces out low otherwise
//   out    : decoded output (combinational)
module phase_out_mux
  import phase_seq_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       enable,
  output logic       out
);

  // Decode the mode code, gated by enable.
  always_comb begin
    out = 1'b0;
    if (enable) begin
      out = mode_out(mode, a, b);
    end else begin
      out = 1'b0;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Timed phase sequencer: steps through NUM_PHASES phases, each held for a
// per-phase dwell count latched on phase entry, with pause/abort control and
// one-shot or looping operation.
//   clk, reset : clock and asynchronous active-high reset
//   bus.start  : begin a sequence from phase 0 (ignored while busy)
//   bus.pause  : freeze counter and phase while high
//   bus.abort  : return to IDLE, overriding everything else
//   bus.loop_en: wrap to phase 0 after the last phase instead of stopping
//   bus.dwell  : per-phase dwell, phase k at [k*CNT_W +: CNT_W] (0 acts as 1)
//   bus.mode   : per-phase output mode, phase k at [2k +: 2]
//   bus.a/b    : operands for the logic output modes
//   bus.out    : phase-dependent output, 0 in IDLE
//   bus.phase  : current phase index
//   bus.busy   : high in RUN or PAUSED
//   bus.step   : one-cycle pulse on each phase advance
//   bus.done   : one-cycle pulse when a one-shot sequence completes
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8,
  parameter int PH_W       = $clog2(NUM_PHASES)
) (
  input logic                clk,
  input logic                reset,
  phase_sequencer_if.slave   bus
);

  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NUM_PHASES - 1);

  state_t             state;
  state_t             state_nx;
  logic [PH_W-1:0]    phase;
  logic [PH_W-1:0]    phase_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic [CNT_W-1:0]   dwell_q;
  logic [CNT_W-1:0]   dwell_nx;
  logic [CNT_W-1:0]   dwell_sel;
  logic               load_dwell;
  logic               step;
  logic               step_nx;
  logic               done;
  logic               done_nx;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= '0;
      cnt     <= '0;
      dwell_q <= '0;
      step    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      cnt     <= cnt_nx;
      dwell_q <= dwell_nx;
      step    <= step_nx;
      done    <= done_nx;
    end
  end

  // Next-state logic. Releasing pause counts that cycle like RUN, so a
  // phase paused for N cycles lasts exactly dwell + N cycles.
  always_comb begin
    state_nx   = state;
    phase_nx   = phase;
    cnt_nx     = cnt;
    step_nx    = 1'b0;
    done_nx    = 1'b0;
    load_dwell = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nx   = RUN;
          phase_nx   = '0;
          cnt_nx     = '0;
          load_dwell = 1'b1;
        end else begin
          state_nx   = IDLE;
        end
      end
      RUN, PAUSED: begin
        if (bus.abort) begin
          state_nx = IDLE;
          phase_nx = '0;
          cnt_nx   = '0;
        end else if (bus.pause) begin
          state_nx = PAUSED;
        end else if (cnt == dwell_q - CNT_W'(1)) begin
          // dwell_q is never 0 once latched, so this compare cannot wrap.
          step_nx    = 1'b1;
          cnt_nx     = '0;
          load_dwell = 1'b1;
          if (phase == LAST_PHASE) begin
            phase_nx = '0;
            if (bus.loop_en) begin
              state_nx = RUN;
            end else begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end else begin
            phase_nx = phase + PH_W'(1);
            state_nx = RUN;
          end
        end else begin
          cnt_nx   = cnt + CNT_W'(1);
          state_nx = RUN;
        end
      end
      default: begin
        state_nx = IDLE;
        phase_nx = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  // Latch the dwell of the phase being entered; a zero dwell is held as 1.
  always_comb begin
    dwell_sel = bus.dwell[int'(phase_nx) * CNT_W +: CNT_W];
    dwell_nx  = dwell_q;
    if (load_dwell) begin
      if (dwell_sel == '0) begin
        dwell_nx = CNT_W'(1);
      end else begin
        dwell_nx = dwell_sel;
      end
    end else begin
      dwell_nx = dwell_q;
    end
  end

  phase_out_mux u_out_mux (
    .mode   (bus.mode[int'(phase) * 2 +: 2]),
    .a      (bus.a),
    .b      (bus.b),
    .enable (state != IDLE),
    .out    (bus.out)
  );

  assign bus.phase = phase;
  assign bus.busy  = (state != IDLE);
  assign bus.step  = step;
  assign bus.done  = done;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer (4 phases, 8-bit dwell).
module tb_phase_sequencer;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  phase_sequencer_if #(.NUM_PHASES(4), .CNT_W(8)) bus ();

  phase_sequencer #(.NUM_PHASES(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // {busy, out, done, step, phase}
  function automatic logic [5:0] ex(input bit busy, input bit o, input bit d, input bit s, input int ph);
    return {busy, o, d, s, ph[1:0]};
  endfunction

  function automatic logic [5:0] obs();
    return {bus.busy, bus.out, bus.done, bus.step, bus.phase};
  endfunction

  // Phase/step per cycle for dwell {6,4,2,1}: phases last 1,2,4,6 cycles.
  int ph_tab [13] = '{0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3};
  bit st_tab [13] = '{1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  // One-shot run with dwell {6,4,2,1}, every mode 01; a stray start mid-run.
  task automatic run_oneshot(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      check($sformatf("%s_c%0d", tag, i), obs(), ex(1, 1, 0, (i != 0) && st_tab[i], ph_tab[i]));
      bus.start = (i == 4);
      tick();
    end
    bus.start = 1'b0;
    check({tag, "_done"}, obs(), ex(0, 0, 1, 1, 0));
    tick();
    check({tag, "_idle"}, obs(), ex(0, 0, 0, 0, 0));
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.pause   = 1'b0;
    bus.abort   = 1'b0;
    bus.loop_en = 1'b0;
    bus.dwell   = {8'd6, 8'd4, 8'd2, 8'd1};
    bus.mode    = 8'b01_01_01_01;
    bus.a       = 1'b0;
    bus.b       = 1'b0;
    tick();
    tick();
    check("reset_state", obs(), ex(0, 0, 0, 0, 0));
    reset = 1'b0;
    tick();

    // One-shot sequence.
    run_oneshot("oneshot");

    // Looping: two full passes, then abort on a phase-0 terminal cycle.
    bus.loop_en = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    for (int i = 0; i < 26; i++) begin
      check($sformatf("loop_c%0d", i), obs(),
            ex(1, 1, 0, (i != 0) && st_tab[i % 13], ph_tab[i % 13]));
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("loop_abort", obs(), ex(0, 0, 0, 0, 0));
    bus.loop_en = 1'b0;

    // start with abort in IDLE stays idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_idle", obs(), ex(0, 0, 0, 0, 0));

    // Zero dwell behaves as one cycle per phase.
    bus.dwell = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dwell0_c%0d", i), obs(), ex(1, 1, 0, i != 0, i));
      tick();
    end
    check("dwell0_done", obs(), ex(0, 0, 1, 1, 0));

    // Pause for 3 cycles inside phase 1 (dwell 5): phase 1 lasts 8 cycles.
    bus.dwell = {8'd6, 8'd4, 8'd5, 8'd1};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("pause_c%0d", i), obs(),
            ex(1, 1, 0, (i == 1) || (i == 9), (i == 0) ? 0 : ((i == 9) ? 2 : 1)));
      bus.pause = (i >= 2) && (i <= 4);
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("pause_abort", obs(), ex(0, 0, 0, 0, 0));

    // Mode 10 in phase 2: a/b sweep, abort on the terminal cycle.
    bus.dwell = {8'd6, 8'd4, 8'd2, 8'd1};
    bus.mode  = 8'b00_10_00_00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("xor_phase", obs(), ex(1, 0, 0, 1, 2));
    for (int k = 0; k < 4; k++) begin
      {bus.a, bus.b} = 2'(k);
      #1;
      check($sformatf("xor_ab%0d", k), {31'd0, bus.out}, (k == 1 || k == 2) ? 32'd1 : 32'd0);
      bus.abort = (k == 3);
      tick();
    end
    bus.abort = 1'b0;
    check("abort_terminal", obs(), ex(0, 0, 0, 0, 0));

    // Mode 11 in phase 2: a/b sweep, pause on the terminal cycle blocks advance.
    bus.mode = 8'b00_11_00_00;
    bus.a    = 1'b0;
    bus.b    = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      {bus.a, bus.b} = 2'(k);
      #1;
      check($sformatf("and_ab%0d", k), {31'd0, bus.out}, (k == 3) ? 32'd1 : 32'd0);
      bus.pause = (k == 3);
      tick();
    end
    check("pause_terminal", obs(), ex(1, 1, 0, 0, 2));
    bus.pause = 1'b0;
    tick();
    check("pause_release_adv", obs(), ex(1, 0, 0, 1, 3));

    // Asynchronous reset mid phase 3, then a fresh full run.
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", obs(), ex(0, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_idle", obs(), ex(0, 0, 0, 0, 0));
    bus.mode = 8'b01_01_01_01;
    bus.a    = 1'b0;
    bus.b    = 1'b0;
    run_oneshot("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
